// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage owning the PC, the imem handshake and the IF/ID register.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   stall, flush          decode backpressure / IF-ID + hold-buffer flush
//   redirect, redirect_pc branch/jump retarget request and target
//   imem_req, imem_addr   fetch request and address (combinational from pc)
//   imem_ack, imem_rdata  fetch completion and returned word
//   ins, npc_o, ins_valid registered IF/ID outputs
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] npc_o,
    output logic        ins_valid
);
    typedef enum logic {RUN, DISCARD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pend_q, pend_d, hold_ins_q, hold_ins_d, hold_npc_q, hold_npc_d;
    logic [31:0] ins_q, ins_d, npc_q, npc_d, pc_inc;
    logic        hold_valid_q, hold_valid_d, valid_q, valid_d, done, accept;
    assign imem_req  = rst_n & ~hold_valid_q;
    assign imem_addr = pc_q;
    assign done      = imem_req & imem_ack;
    assign pc_inc    = pc_q + 32'd4;
    assign ins       = ins_q;
    assign npc_o     = npc_q;
    assign ins_valid = valid_q;
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        hold_ins_d   = hold_ins_q;
        hold_npc_d   = hold_npc_q;
        hold_valid_d = hold_valid_q;
        ins_d        = ins_q;
        npc_d        = npc_q;
        valid_d      = valid_q;
        accept       = 1'b0;
        if (state_q == DISCARD) begin
            if (redirect) pend_d = redirect_pc;
            if (done) begin
                pc_d    = redirect ? redirect_pc : pend_q;
                state_d = RUN;
            end
        end else if (redirect) begin
            // The in-flight address must stay stable, so a mid-wait redirect parks its target.
            hold_valid_d = 1'b0;
            if (!done && imem_req) begin
                pend_d  = redirect_pc;
                state_d = DISCARD;
            end else begin
                pc_d = redirect_pc;
            end
        end else if (done && !flush) begin
            pc_d = pc_inc;
            if (stall) begin
                hold_ins_d   = imem_rdata;
                hold_npc_d   = pc_inc;
                hold_valid_d = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end
        // A redirect discards the held word (wrong path), so it is never loaded that cycle.
        if (flush) begin
            ins_d        = NOP_INS;
            valid_d      = 1'b0;
            hold_valid_d = 1'b0;
        end else if (!stall) begin
            if (hold_valid_q && !redirect) begin
                ins_d        = hold_ins_q;
                npc_d        = hold_npc_q;
                valid_d      = 1'b1;
                hold_valid_d = 1'b0;
            end else if (accept) begin
                ins_d   = imem_rdata;
                npc_d   = pc_inc;
                valid_d = 1'b1;
            end else begin
                ins_d   = NOP_INS;
                valid_d = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pend_q       <= RESET_PC;
            hold_ins_q   <= NOP_INS;
            hold_npc_q   <= 32'd0;
            hold_valid_q <= 1'b0;
            ins_q        <= NOP_INS;
            npc_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            hold_ins_q   <= hold_ins_d;
            hold_npc_q   <= hold_npc_d;
            hold_valid_q <= hold_valid_d;
            ins_q        <= ins_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
        end
    end
endmodule
